mem_access_unit: RTL and testbench

Load/store responder between the core's execute stage and the single-port synchronous data SRAM. It accepts one request at a time over a valid/ready handshake and drives byte-enabled SRAM accesses. For loads it aligns and sign- or zero-extends the read data, which becomes the memory data input of the register-file write-back select. It detects misaligned, out-of-range and illegal-size requests and returns an error response without touching memory.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/load_align.sv | 23 ++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-side memory access unit and its loaders.
// Byte lane i of a 32-bit word holds address offset i (little-endian).
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mau_state_t;

  function automatic logic [3:0] byte_en(input mem_size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = 4'b0011 << {off[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so the enabled lanes see it whatever the offset.
  function automatic logic [31:0] store_lanes(input mem_size_t size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_lanes = {4{d[7:0]}};
      SZ_HALF: store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select plus sign/zero extension; zero latency, no flow control.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder to a synchronous data SRAM, one request in flight.
// Response: error 1 cycle, store 2, load 2+MEM_LAT after accept; no response back-pressure.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int          BA_W     = ADDR_W + 2;
  localparam logic [1:0]  CNT_INIT = 2'(MEM_LAT - 1);

  mau_state_t        state_q, state_d;
  logic              we_q, we_d;
  mem_size_t         size_q, size_d;
  logic              uns_q, uns_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              bad;
  logic [31:0]       ld_data;

  assign accept = req_valid && (state_q == IDLE);

  // Rejected requests never reach the SRAM.
  assign bad = (req_size == SZ_ILLEGAL)
             || ((req_size == SZ_HALF) && req_addr[0])
             || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
             || ((req_addr >> BA_W) != 32'd0);

  load_align u_load_align (
    .rdata_i    (mem_rdata),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Response registers are cleared on accept and after RESP so they read 0 outside the pulse.
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept) begin
      we_d    = req_we;
      size_d  = mem_size_t'(req_size);
      uns_d   = req_unsigned;
      addr_d  = req_addr[BA_W-1:0];
      wdata_d = req_wdata;
      err_d   = bad;
      rdata_d = '0;
    end
    case (state_q)
      ISSUE: cnt_d = CNT_INIT;
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) rdata_d = ld_data;
      end
      RESP: begin
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = err_q;
    resp_rdata = rdata_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_be    = byte_en(size_q, addr_q[1:0]);
      mem_addr  = addr_q[BA_W-1:2];
      mem_wdata = store_lanes(size_q, wdata_q);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: two units (MEM_LAT 1 and 3) with behavioural SRAMs.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic err; logic [31:0] rdata; } rsp_t;
  typedef struct { int cyc; logic we; logic [3:0] be; logic [9:0] addr; logic [31:0] wdata; } mexp_t;
  rsp_t  qa[$];
  rsp_t  qb[$];
  mexp_t ma[$];
  int    b_en_cnt = 0;

  logic        a_valid, a_ready, a_we, a_uns, a_rv, a_err, a_en, a_mwe;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata, a_mwdata, a_mrdata;
  logic [3:0]  a_be;
  logic [9:0]  a_maddr;
  logic        b_valid, b_ready, b_we, b_uns, b_rv, b_err, b_en, b_mwe;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata, b_mwdata, b_mrdata;
  logic [3:0]  b_be;
  logic [9:0]  b_maddr;

  mem_access_unit #(.ADDR_W(10), .MEM_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rv), .resp_err(a_err), .resp_rdata(a_rdata), .mem_en(a_en), .mem_we(a_mwe),
    .mem_be(a_be), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata));

  mem_access_unit #(.ADDR_W(10), .MEM_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_rv), .resp_err(b_err), .resp_rdata(b_rdata), .mem_en(b_en), .mem_we(b_mwe),
    .mem_be(b_be), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata));

  // SRAM models: read data is valid only in the one cycle MEM_LAT after the strobe.
  logic [31:0] amem [0:1023];
  logic [31:0] bmem [0:1023];
  logic [31:0] apipe;
  logic [31:0] bpipe [0:2];

  always @(posedge clk) begin
    if (a_en && a_mwe)
      for (int i = 0; i < 4; i++) if (a_be[i]) amem[a_maddr][8*i +: 8] <= a_mwdata[8*i +: 8];
    apipe <= (a_en && !a_mwe) ? amem[a_maddr] : 32'hBAD0_BAD0;
    bpipe[0] <= (b_en && !b_mwe) ? bmem[b_maddr] : 32'hBAD1_BAD1;
    bpipe[1] <= bpipe[0];
    bpipe[2] <= bpipe[1];
  end
  assign a_mrdata = apipe;
  assign b_mrdata = bpipe[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: got event expected none/other", name);
  endtask

  // Monitors
  always @(negedge clk) begin
    rsp_t  r;
    mexp_t m;
    if (rst_n) begin
      if (a_rv) begin
        if (qa.size() == 0) fail("a_unexpected_resp");
        else begin
          r = qa.pop_front();
          check("a_resp_cycle", 32'(cyc), 32'(r.cyc));
          check("a_resp_err", {31'd0, a_err}, {31'd0, r.err});
          check("a_resp_rdata", a_rdata, r.rdata);
        end
      end else if (a_err || a_rdata != 32'd0) fail("a_resp_idle_nonzero");
      if (a_en) begin
        if (ma.size() == 0) fail("a_unexpected_mem_en");
        else begin
          m = ma.pop_front();
          check("a_mem_cycle", 32'(cyc), 32'(m.cyc));
          check("a_mem_we", {31'd0, a_mwe}, {31'd0, m.we});
          check("a_mem_be", {28'd0, a_be}, {28'd0, m.be});
          check("a_mem_addr", {22'd0, a_maddr}, {22'd0, m.addr});
          if (m.we) check("a_mem_wdata", a_mwdata, m.wdata);
        end
      end
      if (b_en) b_en_cnt++;
      if (b_rv) begin
        if (qb.size() == 0) fail("b_unexpected_resp");
        else begin
          r = qb.pop_front();
          check("b_resp_cycle", 32'(cyc), 32'(r.cyc));
          check("b_resp_err", {31'd0, b_err}, {31'd0, r.err});
          check("b_resp_rdata", b_rdata, r.rdata);
        end
      end
    end
  end

  task automatic issue_a(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic exp_err,
                         input logic [31:0] exp_rd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int n = 0;
    rsp_t r;
    mexp_t m;
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_size = sz; a_uns = uns; a_addr = addr; a_wdata = wd;
    while (!a_ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) fail("a_accept_timeout");
    else begin
      r.cyc = cyc + (exp_err ? 1 : (we ? 2 : 3));
      r.err = exp_err; r.rdata = exp_rd;
      qa.push_back(r);
      if (!exp_err) begin
        m.cyc = cyc + 1; m.we = we; m.be = exp_be; m.addr = addr[11:2]; m.wdata = exp_wd;
        ma.push_back(m);
      end
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_b_ready(output int c);
    int n = 0;
    while (!b_ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) fail("b_accept_timeout");
    c = cyc;
  endtask

  initial begin
    int c0, c1;
    rsp_t r;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    rsp_t r;
    for (int i = 0; i < 1024; i++) begin amem[i] = 32'd0; bmem[i] = 32'd0; end
    bmem[8] = 32'hC3A5_7E01;
    {a_valid, a_we, a_uns, b_valid, b_we, b_uns} = '0;
    {a_size, b_size} = '0;
    {a_addr, a_wdata, b_addr, b_wdata} = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, a_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, a_rv}, 32'd0);
    check("rst_resp_err", {31'd0, a_err}, 32'd0);
    check("rst_resp_rdata", a_rdata, 32'd0);
    check("rst_mem_en", {31'd0, a_en}, 32'd0);
    check("rst_mem_we", {31'd0, a_mwe}, 32'd0);
    check("rst_mem_be", {28'd0, a_be}, 32'd0);
    check("rst_mem_addr", {22'd0, a_maddr}, 32'd0);
    check("rst_mem_wdata", a_mwdata, 32'd0);
    rst_n = 1'b1;

    //       we    size  uns   addr          wdata          err   rdata          be       wdata out
    issue_a(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF);
    issue_a(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    issue_a(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h80FF_1234, 1'b0, 32'h0,         4'b1111, 32'h80FF_1234);
    issue_a(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    issue_a(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_0080, 4'b1000, 32'h0);
    issue_a(1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h0000_ABCD, 1'b0, 32'h0,         4'b1100, 32'hABCD_ABCD);
    issue_a(1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 32'hFFFF_ABCD, 4'b1100, 32'h0);
    issue_a(1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0,         1'b0, 32'h0000_ABCD, 4'b1100, 32'h0);
    issue_a(1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'h0,         1'b0, 32'hFFFF_FFCD, 4'b0100, 32'h0);
    issue_a(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h1234_5677, 1'b0, 32'h0,         4'b0010, 32'h7777_7777);
    issue_a(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_7700, 4'b1111, 32'h0);
    issue_a(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0);
    issue_a(1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0);
    issue_a(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h5555_5555, 1'b1, 32'h0,         4'b0000, 32'h0);
    issue_a(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0);
    issue_a(1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b0, 32'h0,         4'b1111, 32'hA5A5_A5A5);
    issue_a(1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hA5A5_A5A5, 4'b1111, 32'h0);

    // MEM_LAT=3 with req_valid held: second request must be taken 6 cycles after the first.
    @(negedge clk);
    b_en_cnt = 0;
    b_valid = 1'b1; b_we = 1'b0; b_size = 2'd2; b_uns = 1'b0; b_addr = 32'h20;
    wait_b_ready(c0);
    r.cyc = c0 + 5; r.err = 1'b0; r.rdata = 32'hC3A5_7E01; qb.push_back(r);
    @(negedge clk);
    b_size = 2'd1; b_addr = 32'h22;
    wait_b_ready(c1);
    check("b_second_accept_cycle", 32'(c1), 32'(c0 + 6));
    r.cyc = c1 + 5; r.err = 1'b0; r.rdata = 32'hFFFF_C3A5; qb.push_back(r);
    @(negedge clk);
    b_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("b_mem_en_pulses", 32'(b_en_cnt), 32'd2);

    // Reset during WAIT drops the response.
    b_valid = 1'b1; b_size = 2'd2; b_addr = 32'h20;
    wait_b_ready(c0);
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("b_rst_mid_ready", {31'd0, b_ready}, 32'd1);
    check("b_rst_mid_resp_valid", {31'd0, b_rv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b_en_cnt = 0;
    repeat (8) @(negedge clk);
    check("b_post_rst_ready", {31'd0, b_ready}, 32'd1);
    check("b_post_rst_mem_en_pulses", 32'(b_en_cnt), 32'd0);
    check("b_post_rst_outputs", {b_rdata | b_mwdata}, 32'd0);
    check("b_post_rst_ctrl", {22'd0, b_maddr} | {28'd0, b_be} | {31'd0, b_rv | b_err | b_en | b_mwe}, 32'd0);
    check("a_resp_queue_drained", 32'(qa.size()), 32'd0);
    check("a_mem_queue_drained", 32'(ma.size()), 32'd0);
    check("b_resp_queue_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
